mult_seq: RTL

Parametrised sequential shift-add multiplier with valid/ready handshakes on both sides. It is the successor to the team's 8-bit combinational array multiplier, with these additions:
- generalised to WIDTH-bit operands;
- full 2·WIDTH-bit product plus a truncated low half, so existing 8-bit users keep working;
- optional two's-complement mode.

It trades area for latency and sits between operand producers and the accumulator/datapath stages that consume products.

---
 rtl/mult_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mult_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mult_seq                                                   |
// | Description : Sequential shift-add multiplier with valid/ready           |
// |               handshakes on both sides. It retires one multiplier bit    |
// |               per cycle, LSB first. It returns the full 2*WIDTH-bit      |
// |               product p and the truncated low half x.                    |
// | Options     : MULT_SIGNED_EN - when defined, sgn selects two's-          |
// |               complement operands for each operation. When undefined,    |
// |               sgn is ignored and every operation is unsigned.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic [WIDTH-1:0]   x
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  // cnt only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_step;
  logic             ext_bit;

  // True while the bit being retired is the multiplier MSB.
  assign last_step = (cnt == CNT_LAST);

`ifdef MULT_SIGNED_EN
  logic sgn_q;

  // The operand mode is sampled only when an operation is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= sgn;
    end
  end

  // A signed multiplicand is sign-extended across the full product width.
  assign ext_bit = sgn & a[WIDTH-1];

  // In signed mode the multiplier MSB weighs -2^(WIDTH-1), so the last partial product is subtracted.
  always_comb begin
    acc_step = acc + mcand;
    if (sgn_q && last_step) begin
      acc_step = acc - mcand;
    end
  end
`else
  // sgn is present on the port for compatibility only.
  logic unused_sgn;
  assign unused_sgn = sgn;

  // In unsigned-only builds the multiplicand is always zero-extended.
  assign ext_bit = 1'b0;

  // In unsigned-only builds every partial product is added.
  always_comb begin
    acc_step = acc + mcand;
  end
`endif

  // State register. Reset returns to IDLE from any state and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode. in_ready is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load on acceptance, then shift and accumulate one multiplier bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{ext_bit}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) begin
        acc <= acc_step;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_ONE;
    end
  end

  // The accumulator is frozen outside BUSY, so p and x stay stable throughout DONE.
  assign p = acc;
  assign x = acc[WIDTH-1:0];

endmodule
`default_nettype wire
